// File: rtl/stc0_ingress_arb.sv
// Two-requester round-robin ingress arbiter feeding the stc0_core byte port.
// A grant ends on Last, on MAX_BURST beats, or after IDLE_TO idle cycles.
module stc0_ingress_arb #(
   parameter int unsigned MAX_BURST = 16,
   parameter int unsigned IDLE_TO   = 8
) (
   input  logic        Clk,
   input  logic        ARstb,
   input  logic        Valid0,
   input  logic        Valid1,
   input  logic [7:0]  Data0,
   input  logic [7:0]  Data1,
   input  logic        Last0,
   input  logic        Last1,
   output logic        Ack0,
   output logic        Ack1,
   output logic [7:0]  ID,
   output logic        IValid,
   output logic [1:0]  Gnt,
   output logic [15:0] BurstCnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   localparam logic [7:0] MAX_B  = 8'(MAX_BURST);
   localparam logic [7:0] IDLE_B = 8'(IDLE_TO);

   state_t      state;
   logic        last_served;
   logic [7:0]  beat_cnt;
   logic [7:0]  idle_cnt;

   logic        cur_last;
   logic [7:0]  cur_data;
   logic        accept;
   logic [7:0]  beat_inc;
   logic [7:0]  idle_inc;
   logic        release_gnt;

   always_comb begin
      Ack0     = (state == GRANT0) && Valid0;
      Ack1     = (state == GRANT1) && Valid1;
      accept   = Ack0 || Ack1;
      cur_data = (state == GRANT1) ? Data1 : Data0;
      cur_last = (state == GRANT1) ? Last1 : Last0;
      beat_inc = beat_cnt + 8'd1;
      idle_inc = idle_cnt + 8'd1;
      // Last and the burst limit on the same beat fold into one release
      release_gnt = 1'b0;
      if (state != IDLE) begin
         if (accept)
            release_gnt = cur_last || (beat_inc == MAX_B);
         else
            release_gnt = (idle_inc == IDLE_B);
      end
   end

   always_ff @(posedge Clk or negedge ARstb) begin
      if (!ARstb) begin
         state       <= IDLE;
         Gnt         <= 2'b00;
         ID          <= '0;
         IValid      <= 1'b0;
         BurstCnt    <= '0;
         beat_cnt    <= '0;
         idle_cnt    <= '0;
         last_served <= 1'b1;
      end else begin
         IValid <= accept;
         if (accept)
            ID <= cur_data;

         if (state == IDLE) begin
            beat_cnt <= '0;
            idle_cnt <= '0;
            if (Valid0 && (!Valid1 || last_served)) begin
               state <= GRANT0;
               Gnt   <= 2'b01;
            end else if (Valid1) begin
               state <= GRANT1;
               Gnt   <= 2'b10;
            end
         end else begin
            if (accept) begin
               beat_cnt <= beat_inc;
               idle_cnt <= '0;
            end else begin
               idle_cnt <= idle_inc;
            end
            if (release_gnt) begin
               state       <= IDLE;
               Gnt         <= 2'b00;
               last_served <= (state == GRANT1);
               BurstCnt    <= BurstCnt + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_stc0_ingress_arb.sv
// Directed bench for stc0_ingress_arb: two queued requesters, per-cycle output log.
module tb_stc0_ingress_arb;

   logic        Clk = 1'b0;
   logic        ARstb;
   logic        Valid0, Valid1, Last0, Last1;
   logic [7:0]  Data0, Data1;
   logic        Ack0, Ack1;
   logic [7:0]  ID;
   logic        IValid;
   logic [1:0]  Gnt;
   logic [15:0] BurstCnt;

   int tests = 0;
   int fails = 0;

   logic [8:0]  q0[$];
   logic [8:0]  q1[$];
   logic [7:0]  log_id[$];
   logic        log_iv[$];
   logic [1:0]  log_gnt[$];
   logic [15:0] log_bc[$];
   logic        log_a0[$];
   logic        log_a1[$];

   stc0_ingress_arb #(.MAX_BURST(16), .IDLE_TO(8)) dut (
      .Clk(Clk), .ARstb(ARstb),
      .Valid0(Valid0), .Valid1(Valid1),
      .Data0(Data0), .Data1(Data1),
      .Last0(Last0), .Last1(Last1),
      .Ack0(Ack0), .Ack1(Ack1),
      .ID(ID), .IValid(IValid), .Gnt(Gnt), .BurstCnt(BurstCnt)
   );

   always #5 Clk = ~Clk;

   task automatic drive_inputs();
      Valid0 = (q0.size() > 0);
      Data0  = Valid0 ? q0[0][7:0] : 8'h00;
      Last0  = Valid0 ? q0[0][8]   : 1'b0;
      Valid1 = (q1.size() > 0);
      Data1  = Valid1 ? q1[0][7:0] : 8'h00;
      Last1  = Valid1 ? q1[0][8]   : 1'b0;
   endtask

   // One clock: present queue heads, sample Ack mid-cycle, pop accepted bytes, log outputs.
   task automatic tick();
      logic a0, a1;
      drive_inputs();
      #3;
      a0 = Ack0;
      a1 = Ack1;
      log_a0.push_back(a0);
      log_a1.push_back(a1);
      @(posedge Clk);
      #1;
      if (a0) void'(q0.pop_front());
      if (a1) void'(q1.pop_front());
      log_id.push_back(ID);
      log_iv.push_back(IValid);
      log_gnt.push_back(Gnt);
      log_bc.push_back(BurstCnt);
   endtask

   task automatic reset_dut();
      q0.delete(); q1.delete();
      log_id.delete(); log_iv.delete(); log_gnt.delete();
      log_bc.delete(); log_a0.delete(); log_a1.delete();
      drive_inputs();
      @(negedge Clk);
      ARstb = 1'b0;
      @(negedge Clk);
      @(posedge Clk);
      #1;
      ARstb = 1'b1;
   endtask

   task automatic test_reset();
      q0.delete(); q1.delete();
      Valid0 = 1'b1; Valid1 = 1'b1; Data0 = 8'h5A; Data1 = 8'hA5;
      Last0 = 1'b0; Last1 = 1'b0;
      ARstb = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      tests++; if (IValid !== 1'b0) begin fails++; $display("FAIL reset_ivalid got=%b exp=0", IValid); end
      tests++; if (ID !== 8'h00) begin fails++; $display("FAIL reset_id got=%h exp=00", ID); end
      tests++; if (Gnt !== 2'b00) begin fails++; $display("FAIL reset_gnt got=%b exp=00", Gnt); end
      tests++; if (BurstCnt !== 16'h0000) begin fails++; $display("FAIL reset_burstcnt got=%h exp=0000", BurstCnt); end
      tests++; if ({Ack1, Ack0} !== 2'b00) begin fails++; $display("FAIL reset_ack got=%b exp=00", {Ack1, Ack0}); end
   endtask

   task automatic test_round_robin();
      logic [7:0] exp_id[8];
      logic       exp_iv[8];
      logic [1:0] exp_gnt[8];
      reset_dut();
      q0 = '{9'h0A0, 9'h0A1, 9'h1A2};
      q1 = '{9'h0B0, 9'h0B1, 9'h1B2};
      exp_id  = '{8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA2, 8'hB0, 8'hB1, 8'hB2};
      exp_iv  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00};
      repeat (8) tick();
      for (int i = 0; i < 8; i++) begin
         tests++; if (log_iv[i] !== exp_iv[i]) begin fails++; $display("FAIL rr_ivalid[%0d] got=%b exp=%b", i, log_iv[i], exp_iv[i]); end
         tests++; if (log_id[i] !== exp_id[i]) begin fails++; $display("FAIL rr_id[%0d] got=%h exp=%h", i, log_id[i], exp_id[i]); end
         tests++; if (log_gnt[i] !== exp_gnt[i]) begin fails++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", i, log_gnt[i], exp_gnt[i]); end
      end
      tests++; if (BurstCnt !== 16'd2) begin fails++; $display("FAIL rr_burstcnt got=%0d exp=2", BurstCnt); end
   endtask

   task automatic test_max_burst();
      reset_dut();
      for (int i = 0; i < 20; i++) q0.push_back({1'b0, 8'(8'h10 + i)});
      repeat (22) tick();
      for (int i = 1; i <= 16; i++) begin
         tests++; if (log_iv[i] !== 1'b1 || log_id[i] !== 8'(8'h10 + i - 1)) begin
            fails++; $display("FAIL mb_beat[%0d] got=%b/%h exp=1/%h", i, log_iv[i], log_id[i], 8'(8'h10 + i - 1)); end
      end
      tests++; if (log_bc[15] !== 16'd0) begin fails++; $display("FAIL mb_bc_before got=%0d exp=0", log_bc[15]); end
      tests++; if (log_bc[16] !== 16'd1) begin fails++; $display("FAIL mb_bc_release got=%0d exp=1", log_bc[16]); end
      tests++; if (log_gnt[16] !== 2'b00) begin fails++; $display("FAIL mb_gnt_idle got=%b exp=00", log_gnt[16]); end
      tests++; if (log_a0[17] !== 1'b0) begin fails++; $display("FAIL mb_ack_idle got=%b exp=0", log_a0[17]); end
      tests++; if (log_iv[17] !== 1'b0) begin fails++; $display("FAIL mb_bubble got=%b exp=0", log_iv[17]); end
      for (int i = 18; i <= 21; i++) begin
         tests++; if (log_iv[i] !== 1'b1 || log_id[i] !== 8'(8'h20 + i - 18)) begin
            fails++; $display("FAIL mb_tail[%0d] got=%b/%h exp=1/%h", i, log_iv[i], log_id[i], 8'(8'h20 + i - 18)); end
      end
   endtask

   task automatic test_timeout();
      reset_dut();
      q0 = '{9'h001, 9'h002};
      q1 = '{9'h0C0, 9'h1C1};
      repeat (14) tick();
      tests++; if (log_gnt[0] !== 2'b01) begin fails++; $display("FAIL to_first_gnt got=%b exp=01", log_gnt[0]); end
      tests++; if (log_a1[5] !== 1'b0) begin fails++; $display("FAIL to_ack1_blocked got=%b exp=0", log_a1[5]); end
      tests++; if (log_gnt[9] !== 2'b01) begin fails++; $display("FAIL to_gnt_held got=%b exp=01", log_gnt[9]); end
      tests++; if (log_gnt[10] !== 2'b00) begin fails++; $display("FAIL to_release got=%b exp=00", log_gnt[10]); end
      tests++; if (log_bc[10] !== 16'd1) begin fails++; $display("FAIL to_burstcnt got=%0d exp=1", log_bc[10]); end
      tests++; if (log_gnt[11] !== 2'b10) begin fails++; $display("FAIL to_regrant got=%b exp=10", log_gnt[11]); end
      tests++; if (log_iv[12] !== 1'b1 || log_id[12] !== 8'hC0) begin fails++; $display("FAIL to_b0 got=%b/%h exp=1/c0", log_iv[12], log_id[12]); end
   endtask

   task automatic test_reset_mid_grant();
      reset_dut();
      for (int i = 0; i < 8; i++) q1.push_back({1'b0, 8'(8'h30 + i)});
      repeat (5) tick();
      tests++; if (IValid !== 1'b1 || ID !== 8'h33) begin fails++; $display("FAIL rm_beat4 got=%b/%h exp=1/33", IValid, ID); end
      drive_inputs();
      #3;
      ARstb = 1'b0;
      #1;
      tests++; if (IValid !== 1'b0) begin fails++; $display("FAIL rm_ivalid got=%b exp=0", IValid); end
      tests++; if (Gnt !== 2'b00) begin fails++; $display("FAIL rm_gnt got=%b exp=00", Gnt); end
      tests++; if (BurstCnt !== 16'd0) begin fails++; $display("FAIL rm_burstcnt got=%0d exp=0", BurstCnt); end
      tests++; if (Ack1 !== 1'b0) begin fails++; $display("FAIL rm_ack1 got=%b exp=0", Ack1); end
      reset_dut();
      q0 = '{9'h1D0};
      q1 = '{9'h1E0};
      repeat (2) tick();
      tests++; if (log_gnt[0] !== 2'b01) begin fails++; $display("FAIL rm_tie got=%b exp=01", log_gnt[0]); end
      tests++; if (log_id[1] !== 8'hD0) begin fails++; $display("FAIL rm_tie_data got=%h exp=d0", log_id[1]); end
   endtask

   task automatic test_wrap();
      reset_dut();
      @(negedge Clk);
      force dut.BurstCnt = 16'hFFFF;
      @(posedge Clk);
      #1;
      release dut.BurstCnt;
      tests++; if (BurstCnt !== 16'hFFFF) begin fails++; $display("FAIL wrap_preload got=%h exp=ffff", BurstCnt); end
      q0 = '{9'h1EE};
      repeat (3) tick();
      tests++; if (BurstCnt !== 16'h0000) begin fails++; $display("FAIL wrap_burstcnt got=%h exp=0000", BurstCnt); end
   endtask

   task automatic test_last_at_max();
      reset_dut();
      for (int i = 0; i < 15; i++) q0.push_back({1'b0, 8'(8'h40 + i)});
      q0.push_back(9'h14F);
      q0.push_back(9'h150);
      repeat (20) tick();
      tests++; if (log_id[16] !== 8'h4F) begin fails++; $display("FAIL lm_byte16 got=%h exp=4f", log_id[16]); end
      tests++; if (log_bc[16] !== 16'd1) begin fails++; $display("FAIL lm_single_inc got=%0d exp=1", log_bc[16]); end
      tests++; if (log_bc[17] !== 16'd1) begin fails++; $display("FAIL lm_no_double got=%0d exp=1", log_bc[17]); end
      tests++; if (log_gnt[17] !== 2'b01) begin fails++; $display("FAIL lm_regrant got=%b exp=01", log_gnt[17]); end
      tests++; if (log_bc[18] !== 16'd2) begin fails++; $display("FAIL lm_next_pkt got=%0d exp=2", log_bc[18]); end
   endtask

   initial begin
      ARstb = 1'b0;
      test_reset();
      test_round_robin();
      test_max_burst();
      test_timeout();
      test_reset_mid_grant();
      test_wrap();
      test_last_at_max();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
